bin2bcd_seq: RTL and testbench



---
 rtl/bin2bcd_seq_if.sv | 14 +
 rtl/bin2bcd_seq.sv | 100 ++++++++++
 tb/tb_bin2bcd_seq.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// Handshake and digit bus between a bin2bcd_seq converter and its user.
// master drives bin/start; slave (the converter) drives status and digits.
interface bin2bcd_seq_if;
  logic [7:0] bin;
  logic       start;
  logic       busy;
  logic       done;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;

  modport master (output bin, start, input busy, done, hundreds, tens, ones);
  modport slave  (input bin, start, output busy, done, hundreds, tens, ones);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD (double dabble), one bit per clock, 8 cycles start->done.
// Optional leading-zero blanking via `BIN2BCD_LZ_BLANK_EN; start is ignored while busy.
module bin2bcd_seq (
  input  logic          clk,
  input  logic          rst_n,
  bin2bcd_seq_if.slave  conv
);

  typedef enum logic {IDLE, SHIFT} state_t;

`ifdef BIN2BCD_LZ_BLANK_EN
  localparam logic [3:0] HUN_RST = 4'hF;
  localparam logic [3:0] TEN_RST = 4'hF;
`else
  localparam logic [3:0] HUN_RST = 4'h0;
  localparam logic [3:0] TEN_RST = 4'h0;
`endif

  state_t      state_q;
  logic [7:0]  sr_q;
  logic [11:0] bcd_q;
  logic [2:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [3:0]  hun_q, ten_q, one_q;

  logic [11:0] bcd_adj;
  logic [11:0] bcd_d;
  logic [7:0]  sr_d;
  logic [3:0]  hun_d, ten_d, one_d;

  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < 3; n++) begin
      if (bcd_q[n*4 +: 4] >= 4'd5)
        bcd_adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
    end
    bcd_d = {bcd_adj[10:0], sr_q[7]};
    sr_d  = {sr_q[6:0], 1'b0};
    hun_d = bcd_d[11:8];
    ten_d = bcd_d[7:4];
    one_d = bcd_d[3:0];
`ifdef BIN2BCD_LZ_BLANK_EN
    // Blank tens only when hundreds is also zero, so e.g. 105 still shows 1,0,5.
    if (bcd_d[11:8] == 4'd0) begin
      hun_d = 4'hF;
      if (bcd_d[7:4] == 4'd0)
        ten_d = 4'hF;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hun_q   <= HUN_RST;
      ten_q   <= TEN_RST;
      one_q   <= 4'h0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (conv.start) begin
            sr_q    <= conv.bin;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sr_q  <= sr_d;
          bcd_q <= bcd_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            hun_q   <= hun_d;
            ten_q   <= ten_d;
            one_q   <= one_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign conv.busy     = busy_q;
  assign conv.done     = done_q;
  assign conv.hundreds = hun_q;
  assign conv.tens     = ten_q;
  assign conv.ones     = one_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: vector table, multi-cycle corner sequences, full 0..255 sweep.
module tb_bin2bcd_seq;

  logic clk;
  logic rst_n;
  bin2bcd_seq_if cif();

  bin2bcd_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .conv  (cif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0] bin;
    int         h;
    int         t;
    int         o;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Apply leading-zero blanking to a decimal triple when the build enables it.
  function automatic logic [11:0] fmt(input int h, input int t, input int o);
    logic [3:0] hh, tt, oo;
    hh = 4'(h); tt = 4'(t); oo = 4'(o);
`ifdef BIN2BCD_LZ_BLANK_EN
    if (h == 0) begin
      hh = 4'hF;
      if (t == 0) tt = 4'hF;
    end
`endif
    return {hh, tt, oo};
  endfunction

  function automatic logic [11:0] dec_ref(input int v);
    return fmt(v / 100, (v / 10) % 10, v % 10);
  endfunction

  function automatic logic [11:0] digits();
    return {cif.hundreds, cif.tens, cif.ones};
  endfunction

  // Pulse start with v, then count cycles until done (bounded).
  task automatic run_conv(input logic [7:0] v, output logic [11:0] dig,
                          output int lat, output int busy_cnt);
    @(negedge clk);
    cif.bin   = v;
    cif.start = 1'b1;
    @(negedge clk);
    cif.start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!cif.done && lat < 30) begin
      if (cif.busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    dig = digits();
  endtask

  initial begin
    logic [11:0] dig;
    logic [11:0] held;
    int lat, bcnt, ndone, bad;

    vecs[0]  = '{8'd255, 2, 5, 5};
    vecs[1]  = '{8'd0,   0, 0, 0};
    vecs[2]  = '{8'd100, 1, 0, 0};
    vecs[3]  = '{8'd9,   0, 0, 9};
    vecs[4]  = '{8'd10,  0, 1, 0};
    vecs[5]  = '{8'd99,  0, 9, 9};
    vecs[6]  = '{8'd199, 1, 9, 9};
    vecs[7]  = '{8'd128, 1, 2, 8};
    vecs[8]  = '{8'd64,  0, 6, 4};
    vecs[9]  = '{8'd250, 2, 5, 0};
    vecs[10] = '{8'd1,   0, 0, 1};
    vecs[11] = '{8'd37,  0, 3, 7};

    cif.bin   = 8'd0;
    cif.start = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(cif.busy), 32'd0);
    check("reset_done", 32'(cif.done), 32'd0);
    check("reset_digits", 32'(digits()), 32'(fmt(0, 0, 0)));
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_conv(vecs[i].bin, dig, lat, bcnt);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
      check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd8);
      check($sformatf("vec%0d_busy_at_done", i), 32'(cif.busy), 32'd0);
      check($sformatf("vec%0d_digits", i), 32'(dig), 32'(fmt(vecs[i].h, vecs[i].t, vecs[i].o)));
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), 32'(cif.done), 32'd0);
      check($sformatf("vec%0d_digits_hold", i), 32'(digits()), 32'(fmt(vecs[i].h, vecs[i].t, vecs[i].o)));
    end

    // start and bin changes while busy are ignored
    @(negedge clk);
    cif.bin = 8'd123; cif.start = 1'b1;
    @(negedge clk);
    cif.start = 1'b0;
    repeat (3) @(negedge clk);
    cif.bin = 8'd45; cif.start = 1'b1;
    @(negedge clk);
    cif.start = 1'b0;
    ndone = 0;
    held = 12'h000;
    for (int c = 0; c < 20; c++) begin
      if (cif.done) begin ndone++; held = digits(); end
      @(negedge clk);
    end
    check("busy_start_done_count", 32'(ndone), 32'd1);
    check("busy_start_digits", 32'(held), 32'(fmt(1, 2, 3)));
    check("busy_start_no_restart", 32'(cif.busy), 32'd0);

    // start held high: a conversion every 9 cycles
    cif.bin = 8'd200; cif.start = 1'b1;
    lat = 0;
    while (!cif.done && lat < 30) begin @(negedge clk); lat++; end
    check("held_first_digits", 32'(digits()), 32'(fmt(2, 0, 0)));
    held = digits();
    cif.bin = 8'd201;
    @(negedge clk);
    lat = 1; bad = 0;
    while (!cif.done && lat < 30) begin
      if (digits() !== held) bad++;
      @(negedge clk);
      lat++;
    end
    check("held_period", 32'(lat), 32'd9);
    check("held_digits_stable", 32'(bad), 32'd0);
    check("held_second_digits", 32'(digits()), 32'(fmt(2, 0, 1)));
    cif.start = 1'b0;
    repeat (12) @(negedge clk);
    check("held_release_idle", 32'(cif.busy), 32'd0);

    // reset four cycles into a conversion
    cif.bin = 8'd99; cif.start = 1'b1;
    @(negedge clk);
    cif.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_busy", 32'(cif.busy), 32'd0);
    check("midreset_done", 32'(cif.done), 32'd0);
    check("midreset_digits", 32'(digits()), 32'(fmt(0, 0, 0)));
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (cif.done) ndone++;
      @(negedge clk);
    end
    check("midreset_no_done", 32'(ndone), 32'd0);
    check("midreset_digits_after", 32'(digits()), 32'(fmt(0, 0, 0)));
    run_conv(8'd42, dig, lat, bcnt);
    check("post_reset_latency", 32'(lat), 32'd8);
    check("post_reset_digits", 32'(dig), 32'(fmt(0, 4, 2)));

    // exhaustive sweep
    bad = 0;
    for (int v = 0; v < 256; v++) begin
      run_conv(8'(v), dig, lat, bcnt);
      check($sformatf("sweep_%0d", v), 32'(dig), 32'(dec_ref(v)));
      for (int n = 0; n < 3; n++) begin
        if (dig[n*4 +: 4] > 4'd9 && !(dig[n*4 +: 4] == 4'hF && n > 0)) bad++;
      end
      if (dig[11:8] > 4'd2 && dig[11:8] != 4'hF) bad++;
    end
    check("sweep_digit_range", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
